dpsram_tdp: RTL
===============

// Module: dpsram_tdp
// PURPOSE
//  Single-clock true-dual-port SRAM model with per-byte write enables, configurable read latency,
//  defined same-address collision semantics and an optional post-reset clear sweep.
//  Successor of the unclocked-semantics dual-port RAM; used by caches/queues needing deterministic collisions.
// PARAMETERS
//  W          32  data width in bits; must be a multiple of 8
//  N          128 number of entries; need not be a power of two
//  RD_LAT     1   read latency in cycles; legal values 1 or 2
//  WR_FIRST   1   1: a same-address read returns newly written bytes; 0: returns old data
//  INIT_EN    1   1: clear all N entries to INIT_VAL after reset deasserts
//  INIT_VAL   '0  W-bit clear value
// PORTS
//  clk        in   1          single clock, all logic on posedge
//  rst_n      in   1          reset, asynchronous, active-low
//  busy       out  1          clear sweep in progress; requests ignored while high
//  en1/en2    in   1          port request
//  wen1/wen2  in   1          1 = write, 0 = read (qualified by en)
//  be1/be2    in   W/8        byte write enables (ignored on reads)
//  addr1/2    in   $clog2(N)  entry address
//  din1/din2  in   W          write data
//  dout1/2    out  W          read data, valid when rvalid
//  rvalid1/2  out  1          read data valid strobe
//  collide    out  1          registered pulse: both ports enabled to the same address, at least one writing
// BEHAVIOUR
//  Reset: dout*=0, rvalid*=0, collide=0, busy=INIT_EN. Pipelines and sweep counter cleared asynchronously.
//  Reset mid-sweep or mid-read: in-flight reads dropped (no rvalid); sweep restarts from 0.
//  Sweep (INIT_EN=1), FSM with states INIT and RUN:
//   - INIT writes INIT_VAL to entry cnt each cycle, cnt 0..N-1.
//   - At cnt==N-1: next state RUN, busy drops.
//   - busy is high for exactly N cycles after the first clk following rst_n rise.
//   - With INIT_EN=0 the FSM starts in RUN and memory contents are X.
//  Accept: req accepted iff en & ~busy. Writes update the bytes with be set at posedge; be==0 is a no-op write.
//  Read: accepted read at edge T -> dout/rvalid at edge T+RD_LAT.
//   - rvalid high for one cycle per read; back-to-back reads give continuous rvalid.
//   - dout holds its last value when rvalid is low; it is never X-driven.
//  Write-write, same address: byte-level merge.
//   - Bytes with be1 set take din1 (port 1 wins).
//   - Remaining bytes with be2 set take din2.
//  Read-write across ports, same address:
//   - WR_FIRST=1: the reader sees the merged post-write word.
//   - WR_FIRST=0: the reader sees the pre-write word.
//  Both ports reading the same address: no conflict; both receive the same data.
//  collide is asserted one cycle after any same-address event in which at least one port writes.
//  Out of range (addr>=N, N not a power of two):
//   - Writes are dropped.
//   - Reads return INIT_VAL with rvalid asserted.
//   - A sim-only assertion fires.
//  Static asserts: W%8==0; RD_LAT in {1,2}.
// STRUCTURE
//  Package dpsram_pkg:
//   - typedefs: state_t enum {INIT, RUN}.
//   - function be_merge(old, din, be): per-byte mux returning W bits.
//  Sub-module dpsram_rdpipe: per-port valid/data pipeline of depth RD_LAT-1 with a hold register.
//   Instantiated twice.
//  Top holds the array, collision/merge logic and the sweep FSM.
// TESTING
//  1. Reset, INIT_EN=1, N=128:
//     - busy high 128 cycles.
//     - en1 read addr 5 during busy -> no rvalid1.
//     - read addr 127 after busy drops -> dout1=0.
//  2. RD_LAT=2: write 0xDEADBEEF @3 (be=4'hF), then read @3 at T -> rvalid1 and dout1=0xDEADBEEF at T+2 only.
//  3. Byte-enable merge, same cycle @9, collide=1 next cycle, then read @9 -> 0x11222211:
//     - Port 1 writes 0x11111111 be=4'b1001.
//     - Port 2 writes 0x22222222 be=4'b1111.
//  4. Read/write collision: word @7=0xAAAA0000; port 1 reads @7 while port 2 writes 0x0000BBBB be=4'b0011:
//     - WR_FIRST=1 -> dout1=0xAAAABBBB.
//     - WR_FIRST=0 -> dout1=0xAAAA0000.
//  5. rst_n low mid-sweep at cnt=40 and with a read in flight:
//     - rvalid never asserts for that read.
//     - busy then lasts 128 full cycles.
//  6. N=100: write @110 dropped; read @110 -> rvalid, dout=INIT_VAL, assertion fires.

Source files
------------

// File: rtl/dpsram_pkg.sv
// Shared types and helpers for the dpsram_tdp true-dual-port RAM.
//   state_t  : clear-sweep FSM state (INIT while clearing, RUN afterwards)
//   be_merge : per-byte mux, bytes with be set come from din, the rest from old.
//              Operates at MAX_W bits so any legal W (multiple of 8, <= MAX_W)
//              can zero-extend into it and slice the result back down.
package dpsram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MAX_W = 512;
  localparam int MAX_B = MAX_W / 8;

  function automatic logic [MAX_W-1:0] be_merge(
    input logic [MAX_W-1:0] old,
    input logic [MAX_W-1:0] din,
    input logic [MAX_B-1:0] be
  );
    logic [MAX_W-1:0] res;
    res = old;
    for (int b = 0; b < MAX_B; b++) begin
      if (be[b]) res[8*b +: 8] = din[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpsram_tdp_if.sv
// Port bundle for dpsram_tdp.
//   Request side (per port n = 1, 2): en, wen, be, addr, din.
//   Response side: dout, rvalid per port; busy, collide, dbg_state shared.
// Handshake: a request is taken on a rising clk edge where en is high and busy
// is low; there is no ready/backpressure beyond busy. Read data comes back as
// a one-cycle rvalid strobe RD_LAT edges later and cannot be stalled; dout
// keeps its last value while rvalid is low.
interface dpsram_tdp_if
  import dpsram_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 128
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic          en1, wen1, en2, wen2;
  logic [W/8-1:0] be1, be2;
  logic [AW-1:0] addr1, addr2;
  logic [W-1:0]  din1, din2;
  logic [W-1:0]  dout1, dout2;
  logic          rvalid1, rvalid2;
  logic          busy;
  logic          collide;
  state_t        dbg_state;

  modport master (
    output en1, wen1, be1, addr1, din1,
    output en2, wen2, be2, addr2, din2,
    input  dout1, rvalid1, dout2, rvalid2, busy, collide, dbg_state
  );

  modport slave (
    input  en1, wen1, be1, addr1, din1,
    input  en2, wen2, be2, addr2, din2,
    output dout1, rvalid1, dout2, rvalid2, busy, collide, dbg_state
  );
endinterface

// File: rtl/dpsram_rdpipe.sv
// Read-response pipeline for one RAM port.
//   in_valid/in_data : read accepted this edge and the word it returns
//   out_valid/out_data : strobe and held data, RD_LAT edges after acceptance
// RD_LAT-1 plain stages followed by a hold register that only loads on valid,
// so out_data keeps the last returned word between reads.
module dpsram_rdpipe #(
  parameter int W      = 32,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic         s_valid;
  logic [W-1:0] s_data;

  if (RD_LAT == 2) begin : g_stage
    logic         v_q;
    logic [W-1:0] d_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= in_valid;
        if (in_valid) d_q <= in_data;
      end
    end
    assign s_valid = v_q;
    assign s_data  = d_q;
  end else begin : g_pass
    assign s_valid = in_valid;
    assign s_data  = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= s_valid;
      if (s_valid) out_data <= s_data;
    end
  end
endmodule

// File: rtl/dpsram_tdp.sv
// Single-clock true-dual-port SRAM with byte enables, RD_LAT 1/2 read
// pipelines, deterministic same-address collisions and a post-reset clear.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : dpsram_tdp_if slave (requests in, dout/rvalid/busy/collide out)
// Same-address rules: write/write merges per byte with port 1 winning;
// read/write returns the post-write word when WR_FIRST else the pre-write word.
// Out-of-range addresses (N not a power of two) drop writes and read INIT_VAL.
// The bus interface must be instantiated with the same W and N.
module dpsram_tdp
  import dpsram_pkg::*;
#(
  parameter int           W        = 32,
  parameter int           N        = 128,
  parameter int           RD_LAT   = 1,
  parameter bit           WR_FIRST = 1'b1,
  parameter bit           INIT_EN  = 1'b1,
  parameter logic [W-1:0] INIT_VAL = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  dpsram_tdp_if.slave bus
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = W / 8;

  if ((W % 8) != 0 || W > MAX_W) begin : g_bad_w
    $error("dpsram_tdp: W must be a multiple of 8 and at most MAX_W");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("dpsram_tdp: RD_LAT must be 1 or 2");
  end

  function automatic logic [W-1:0] merge_w(input logic [W-1:0] old,
                                           input logic [W-1:0] din,
                                           input logic [BW-1:0] be);
    logic [MAX_W-1:0] full;
    full = be_merge(MAX_W'(old), MAX_W'(din), MAX_B'(be));
    return full[W-1:0];
  endfunction

  logic [W-1:0]  mem [N];
  state_t        state;
  logic [AW-1:0] cnt;
  logic          busy;
  logic          collide;

  // Sweep FSM: INIT clears entry cnt each edge; busy falls with the last entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_EN ? INIT : RUN;
      cnt   <= '0;
      busy  <= INIT_EN;
    end else if (state == INIT) begin
      if (int'(cnt) == N - 1) begin
        state <= RUN;
        busy  <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  logic acc1, acc2, in1, in2, wr1, wr2, rd1, rd2, same;
  logic [W-1:0] old1, old2, wm1, wm2, wboth, rdata1, rdata2;

  // Power-of-two depth has no unreachable addresses.
  if (N == (1 << AW)) begin : g_full
    assign in1 = 1'b1;
    assign in2 = 1'b1;
  end else begin : g_part
    assign in1 = int'(bus.addr1) < N;
    assign in2 = int'(bus.addr2) < N;
  end

  assign acc1 = bus.en1 & ~busy;
  assign acc2 = bus.en2 & ~busy;
  assign wr1  = acc1 & bus.wen1 & in1;
  assign wr2  = acc2 & bus.wen2 & in2;
  assign rd1  = acc1 & ~bus.wen1;
  assign rd2  = acc2 & ~bus.wen2;
  assign same = bus.addr1 == bus.addr2;

  assign old1  = in1 ? mem[bus.addr1] : INIT_VAL;
  assign old2  = in2 ? mem[bus.addr2] : INIT_VAL;
  assign wm1   = merge_w(old1, bus.din1, bus.be1);
  assign wm2   = merge_w(old2, bus.din2, bus.be2);
  // Port 2 applied first so port 1's enabled bytes land on top.
  assign wboth = merge_w(wm2, bus.din1, bus.be1);

  // A reading port can only collide with the other port's write.
  assign rdata1 = !in1 ? INIT_VAL : (WR_FIRST && wr2 && same) ? wm2 : old1;
  assign rdata2 = !in2 ? INIT_VAL : (WR_FIRST && wr1 && same) ? wm1 : old2;

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[cnt] <= INIT_VAL;
    end else if (wr1 && wr2 && same) begin
      mem[bus.addr1] <= wboth;
    end else begin
      if (wr1) mem[bus.addr1] <= wm1;
      if (wr2) mem[bus.addr2] <= wm2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collide <= 1'b0;
    else        collide <= acc1 & acc2 & same & (bus.wen1 | bus.wen2);
  end

  dpsram_rdpipe #(.W(W), .RD_LAT(RD_LAT)) u_rp1 (
    .clk(clk), .rst_n(rst_n), .in_valid(rd1), .in_data(rdata1),
    .out_valid(bus.rvalid1), .out_data(bus.dout1)
  );

  dpsram_rdpipe #(.W(W), .RD_LAT(RD_LAT)) u_rp2 (
    .clk(clk), .rst_n(rst_n), .in_valid(rd2), .in_data(rdata2),
    .out_valid(bus.rvalid2), .out_data(bus.dout2)
  );

  assign bus.busy      = busy;
  assign bus.collide   = collide;
  assign bus.dbg_state = state;

  // Simulation-only notice for accesses beyond the last entry.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(acc1 && !in1))
        else $warning("dpsram_tdp: port 1 access to out-of-range address %0d", bus.addr1);
      assert (!(acc2 && !in2))
        else $warning("dpsram_tdp: port 2 access to out-of-range address %0d", bus.addr2);
    end
  end
endmodule
